// File: rtl/shadow_chain_controller_if.sv
// Bundle of the chain-side and lane-side serial signals of the shadow chain crossbar.
// The master drives chains and lane enables; the slave is the controller.
interface shadow_chain_controller_if #(
    parameter int unsigned CHAINS_IN  = 5,
    parameter int unsigned CHAINS_OUT = 3
);
    logic [CHAINS_IN-1:0]  cin_ready;
    logic [CHAINS_IN-1:0]  cin_done;
    logic [CHAINS_IN-1:0]  cin;
    logic [CHAINS_IN-1:0]  cin_en;
    logic [CHAINS_OUT-1:0] cout_en;
    logic [CHAINS_OUT-1:0] cout;
    logic [CHAINS_OUT-1:0] cout_status;

    modport master (
        output cin_ready, cin_done, cin, cout_en,
        input  cin_en, cout, cout_status
    );

    modport slave (
        input  cin_ready, cin_done, cin, cout_en,
        output cin_en, cout, cout_status
    );
endinterface

// File: rtl/shadow_chain_controller.sv
// Fixed-priority crossbar granting free output lanes to ready shadow chains and
// passing the chain's serial bits straight through until the chain reports done.
module shadow_chain_controller #(
    parameter int unsigned CHAINS_IN  = 5,
    parameter int unsigned CHAINS_OUT = 3
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    shadow_chain_controller_if.slave  bus
);
    localparam int unsigned SEL_W = (CHAINS_IN > 1) ? $clog2(CHAINS_IN) : 1;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    logic [0:0]            r_state [CHAINS_OUT];
    logic [SEL_W-1:0]      r_sel   [CHAINS_OUT];

    logic [CHAINS_OUT-1:0] w_busy;
    logic [CHAINS_OUT-1:0] w_last;
    logic [CHAINS_OUT-1:0] w_grant;
    logic [SEL_W-1:0]      w_gidx  [CHAINS_OUT];
    logic [CHAINS_IN-1:0]  w_held;
    logic [CHAINS_IN-1:0]  w_taken;

    // Lane datapath: purely combinational from lane state, so data adds no latency.
    always_comb begin
        w_busy          = '0;
        w_last          = '0;
        w_held          = '0;
        bus.cin_en      = '0;
        bus.cout        = '0;
        bus.cout_status = '0;
        for (int unsigned j = 0; j < CHAINS_OUT; j++) begin
            w_busy[j] = (r_state[j] == STREAM);
            if (w_busy[j]) begin
                bus.cout_status[j] = bus.cout_en[j];
                for (int unsigned i = 0; i < CHAINS_IN; i++) begin
                    if (r_sel[j] == SEL_W'(i)) begin
                        w_held[i]     = 1'b1;
                        bus.cin_en[i] = bus.cout_en[j];
                        bus.cout[j]   = bus.cin[i];
                        w_last[j]     = bus.cin_done[i] & bus.cout_en[j];
                    end
                end
            end
        end
    end

    // Grants see pre-edge ownership, so a chain releasing this cycle stays excluded;
    // each grant marks its chain taken before higher lanes are considered.
    always_comb begin
        w_taken = w_held;
        w_grant = '0;
        for (int unsigned j = 0; j < CHAINS_OUT; j++) begin
            w_gidx[j] = '0;
        end
        for (int unsigned j = 0; j < CHAINS_OUT; j++) begin
            if (!w_busy[j] && bus.cout_en[j]) begin
                for (int unsigned i = 0; i < CHAINS_IN; i++) begin
                    if (!w_grant[j] && bus.cin_ready[i] && !bus.cin_done[i] && !w_taken[i]) begin
                        w_grant[j] = 1'b1;
                        w_gidx[j]  = SEL_W'(i);
                        w_taken[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned j = 0; j < CHAINS_OUT; j++) begin
                r_state[j] <= IDLE;
                r_sel[j]   <= '0;
            end
        end else begin
            for (int unsigned j = 0; j < CHAINS_OUT; j++) begin
                case (r_state[j])
                    IDLE: begin
                        if (w_grant[j]) begin
                            r_state[j] <= STREAM;
                            r_sel[j]   <= w_gidx[j];
                        end
                    end
                    STREAM: begin
                        if (w_last[j]) begin
                            r_state[j] <= IDLE;
                        end
                    end
                    default: r_state[j] <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_shadow_chain_controller.sv
// Directed bench for shadow_chain_controller: 8-bit chain models, lane capture,
// hand-computed expected lane streams and enable patterns.
module tb_shadow_chain_controller;
    localparam int unsigned NI = 5;
    localparam int unsigned NO = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [7:0]    ch_data [NI];
    int            ch_cnt  [NI];
    logic [NI-1:0] ch_rdy;
    logic [15:0]   cap     [NO];
    int            cap_n   [NO];

    shadow_chain_controller_if #(.CHAINS_IN(NI), .CHAINS_OUT(NO)) bus ();

    shadow_chain_controller #(.CHAINS_IN(NI), .CHAINS_OUT(NO)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_chains();
        for (int i = 0; i < NI; i++) begin
            bus.cin[i]      = ch_rdy[i] ? ch_data[i][7-ch_cnt[i]] : 1'b0;
            bus.cin_done[i] = ch_rdy[i] && (ch_cnt[i] == 7);
        end
        bus.cin_ready = ch_rdy;
    endtask

    task automatic load(input int i, input logic [7:0] d);
        ch_data[i] = d;
        ch_cnt[i]  = 0;
        ch_rdy[i]  = 1'b1;
    endtask

    task automatic clear_caps();
        for (int j = 0; j < NO; j++) begin
            cap[j]   = '0;
            cap_n[j] = 0;
        end
    endtask

    // Capture lane bits before the edge, then advance chains that were enabled.
    task automatic cycle();
        logic [NI-1:0] en_s;
        en_s = bus.cin_en;
        for (int j = 0; j < NO; j++) begin
            if (bus.cout_status[j]) begin
                cap[j]   = {cap[j][14:0], bus.cout[j]};
                cap_n[j] = cap_n[j] + 1;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            if (en_s[i]) begin
                if (ch_cnt[i] == 7) begin
                    ch_rdy[i] = 1'b0;
                    ch_cnt[i] = 0;
                end else begin
                    ch_cnt[i] = ch_cnt[i] + 1;
                end
            end
        end
        drive_chains();
        #1;
    endtask

    task automatic drain(input int max);
        int k;
        k = 0;
        while ((ch_rdy != '0 || bus.cin_en != '0) && k < max) begin
            cycle();
            k++;
        end
        check("drain_done", 32'(ch_rdy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ch_rdy = '0;
        for (int i = 0; i < NI; i++) begin
            ch_data[i] = '0;
            ch_cnt[i]  = 0;
        end
        clear_caps();
        bus.cin_ready = '0;
        bus.cin_done  = '0;
        bus.cin       = '0;
        bus.cout_en   = '0;
        #1 rst_n = 1'b0;

        // Inputs toggle freely while reset is held; outputs must stay quiet.
        for (int r = 0; r < 4; r++) begin
            bus.cin_ready = NI'($urandom);
            bus.cin_done  = NI'($urandom);
            bus.cin       = NI'($urandom);
            bus.cout_en   = NO'($urandom);
            @(posedge clk);
            #1;
            check("rst_cin_en", 32'(bus.cin_en), 32'd0);
            check("rst_cout", 32'(bus.cout), 32'd0);
            check("rst_status", 32'(bus.cout_status), 32'd0);
        end

        bus.cout_en = 3'b111;
        drive_chains();
        rst_n = 1'b1;
        cycle();
        cycle();
        check("idle_cin_en", 32'(bus.cin_en), 32'd0);
        check("idle_cout", 32'(bus.cout), 32'd0);
        check("idle_status", 32'(bus.cout_status), 32'd0);

        // Five chains, three lanes.
        clear_caps();
        for (int i = 0; i < NI; i++) load(i, 8'hAB + 8'(i));
        drive_chains();
        cycle();
        check("alloc_cin_en", 32'(bus.cin_en), 32'h07);
        check("alloc_status", 32'(bus.cout_status), 32'h7);
        check("alloc_first_bits", 32'(bus.cout), 32'h7);
        repeat (8) cycle();
        check("gap_cin_en", 32'(bus.cin_en), 32'd0);
        check("gap_status", 32'(bus.cout_status), 32'd0);
        cycle();
        check("queue_cin_en", 32'(bus.cin_en), 32'h18);
        check("queue_status", 32'(bus.cout_status), 32'h3);
        repeat (8) cycle();
        check("queue_end_cin_en", 32'(bus.cin_en), 32'd0);
        check("queue_end_status", 32'(bus.cout_status), 32'd0);
        check("lane0_stream", 32'(cap[0]), 32'hABAE);
        check("lane0_bits", 32'(cap_n[0]), 32'd16);
        check("lane1_stream", 32'(cap[1]), 32'hACAF);
        check("lane1_bits", 32'(cap_n[1]), 32'd16);
        check("lane2_stream", 32'(cap[2][7:0]), 32'hAD);
        check("lane2_bits", 32'(cap_n[2]), 32'd8);

        // Backpressure on lane 1 for three cycles mid-stream.
        clear_caps();
        load(0, 8'h5A);
        load(1, 8'h3C);
        bus.cout_en = 3'b011;
        drive_chains();
        cycle();
        check("bp_grant_en", 32'(bus.cin_en), 32'h03);
        repeat (3) cycle();
        bus.cout_en = 3'b001;
        #1;
        for (int p = 0; p < 3; p++) begin
            check("bp_cin_en1", 32'(bus.cin_en[1]), 32'd0);
            check("bp_status1", 32'(bus.cout_status[1]), 32'd0);
            cycle();
        end
        bus.cout_en = 3'b011;
        #1;
        drain(30);
        check("bp_lane0_stream", 32'(cap[0][7:0]), 32'h5A);
        check("bp_lane0_bits", 32'(cap_n[0]), 32'd8);
        check("bp_lane1_stream", 32'(cap[1][7:0]), 32'h3C);
        check("bp_lane1_bits", 32'(cap_n[1]), 32'd8);

        // Fixed priority with a single enabled lane.
        clear_caps();
        load(2, 8'h96);
        load(4, 8'h0F);
        bus.cout_en = 3'b001;
        drive_chains();
        cycle();
        check("prio_first_en", 32'(bus.cin_en), 32'h04);
        check("prio_first_status", 32'(bus.cout_status), 32'h1);
        repeat (8) cycle();
        check("prio_gap_en", 32'(bus.cin_en), 32'd0);
        cycle();
        check("prio_second_en", 32'(bus.cin_en), 32'h10);
        repeat (8) cycle();
        check("prio_end_en", 32'(bus.cin_en), 32'd0);
        check("prio_stream", 32'(cap[0]), 32'h960F);
        check("prio_bits", 32'(cap_n[0]), 32'd16);

        // Asynchronous reset mid-stream, then re-grant from lane 0.
        clear_caps();
        load(0, 8'hC3);
        load(1, 8'h91);
        bus.cout_en = 3'b111;
        drive_chains();
        cycle();
        repeat (3) cycle();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_cin_en", 32'(bus.cin_en), 32'd0);
        check("mid_rst_cout", 32'(bus.cout), 32'd0);
        check("mid_rst_status", 32'(bus.cout_status), 32'd0);
        cycle();
        rst_n = 1'b1;
        cycle();
        check("regrant_cin_en", 32'(bus.cin_en), 32'h03);
        check("regrant_status", 32'(bus.cout_status), 32'h3);
        check("regrant_cout", 32'(bus.cout), 32'h2);
        drain(30);
        check("regrant_lane0", 32'(cap[0][7:0]), 32'hC3);
        check("regrant_lane1", 32'(cap[1][7:0]), 32'h91);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
